// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: opcodes, state codes,
// datapath select codes and the decoded instruction-class vector.
package mc_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] FunctJr = 6'b001000;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StJmp    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    AluRtype = 3'b000,
    AluMem   = 3'b001,
    AluBeq   = 3'b010,
    AluLui   = 3'b011,
    AluOri   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    PcSeq    = 2'b00,
    PcBranch = 2'b01,
    PcJump   = 2'b10,
    PcRs     = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    DstRt = 2'b00,
    DstRd = 2'b01,
    DstRa = 2'b10
  } reg_dst_e;

  typedef enum logic [1:0] {
    WbAlu = 2'b00,
    WbLui = 2'b01,
    WbMem = 2'b10,
    WbPc4 = 2'b11
  } mem_to_reg_e;

  // One-hot instruction class; all-zero means illegal.
  typedef struct packed {
    logic r;
    logic lw;
    logic sw;
    logic lui;
    logic ori;
    logic beq;
    logic jal;
    logic jr;
  } instr_cls_t;

  typedef struct packed {
    logic        pc_write;
    logic        ir_write;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        ext_op;
    logic        instr_done;
    logic        illegal;
    reg_dst_e    reg_dst;
    mem_to_reg_e mem_to_reg;
    pc_src_e     pc_src;
    alu_op_e     alu_op;
  } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/funct to one-hot class plus illegal flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output instr_cls_t cls_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o = '0;
    case (op_i)
      OpRtype: begin
        if (funct_i == FunctJr) cls_o.jr = 1'b1;
        else                    cls_o.r  = 1'b1;
      end
      OpLw:    cls_o.lw  = 1'b1;
      OpSw:    cls_o.sw  = 1'b1;
      OpLui:   cls_o.lui = 1'b1;
      OpOri:   cls_o.ori = 1'b1;
      OpBeq:   cls_o.beq = 1'b1;
      OpJal:   cls_o.jal = 1'b1;
      default: ;
    endcase
  end

  assign illegal_o = ~|cls_o;

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM. Define MCCTRL_MEM_WAIT_EN to add the mem_ready
// handshake that stretches FETCH and MEM until memory completes.
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned STATE_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
`ifdef MCCTRL_MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               ALUSrc,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               ExtOp,
  output logic               instr_done,
  output logic               illegal,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         PCSrc,
  output logic [2:0]         ALUOp,
  output logic [STATE_W-1:0] state
);

  state_e     state_q, state_d;
  instr_cls_t cls;
  logic       dec_illegal;
  logic       mem_rdy;
  ctrl_t      ctrl, ctrl_out;

`ifdef MCCTRL_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  mc_decode u_decode (
    .op_i      (op),
    .funct_i   (funct),
    .cls_o     (cls),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      StFetch: begin
        ctrl.mem_read = 1'b1;
        if (mem_rdy) begin
          ctrl.pc_write = 1'b1;
          ctrl.ir_write = 1'b1;
          state_d       = StDecode;
        end
      end
      StDecode: begin
        if (cls.jal || cls.jr) begin
          state_d = StJmp;
        end else if (dec_illegal) begin
          ctrl.illegal = 1'b1;
          state_d      = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StWb;
        unique case (1'b1)
          cls.r: ctrl.alu_op = AluRtype;
          cls.lw, cls.sw: begin
            ctrl.alu_op  = AluMem;
            ctrl.alu_src = 1'b1;
            state_d      = StMem;
          end
          cls.beq: begin
            ctrl.alu_op     = AluBeq;
            ctrl.pc_src     = PcBranch;
            ctrl.pc_write   = zero;
            ctrl.instr_done = 1'b1;
            state_d         = StFetch;
          end
          cls.lui: ctrl.alu_op = AluLui;
          cls.ori: begin
            ctrl.alu_op  = AluOri;
            ctrl.alu_src = 1'b1;
            ctrl.ext_op  = 1'b1;
          end
          default: state_d = StFetch;
        endcase
      end
      StMem: begin
        state_d = StFetch;
        if (cls.lw) begin
          ctrl.mem_read = 1'b1;
          state_d       = mem_rdy ? StWb : StMem;
        end else if (cls.sw) begin
          ctrl.mem_write  = 1'b1;
          ctrl.instr_done = mem_rdy;
          state_d         = mem_rdy ? StFetch : StMem;
        end
      end
      StWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = StFetch;
        unique case (1'b1)
          cls.r:   ctrl.reg_dst    = DstRd;
          cls.lw:  ctrl.mem_to_reg = WbMem;
          cls.lui: ctrl.mem_to_reg = WbLui;
          default: ;
        endcase
      end
      StJmp: begin
        ctrl.instr_done = 1'b1;
        state_d         = StFetch;
        if (cls.jal) begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_src     = PcJump;
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = DstRa;
          ctrl.mem_to_reg = WbPc4;
        end else if (cls.jr) begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PcRs;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  // Reset masks every strobe combinationally, so nothing fires while it is held.
  always_comb begin
    ctrl_out = ctrl;
    if (reset) ctrl_out = '0;
  end

  assign PCWrite    = ctrl_out.pc_write;
  assign IRWrite    = ctrl_out.ir_write;
  assign ALUSrc     = ctrl_out.alu_src;
  assign RegWrite   = ctrl_out.reg_write;
  assign MemRead    = ctrl_out.mem_read;
  assign MemWrite   = ctrl_out.mem_write;
  assign ExtOp      = ctrl_out.ext_op;
  assign instr_done = ctrl_out.instr_done;
  assign illegal    = ctrl_out.illegal;
  assign RegDst     = ctrl_out.reg_dst;
  assign MemtoReg   = ctrl_out.mem_to_reg;
  assign PCSrc      = ctrl_out.pc_src;
  assign ALUOp      = ctrl_out.alu_op;
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each queued row carries the cycle's stimulus and the
// state/strobe vector expected in that cycle.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       PCWrite, IRWrite, ALUSrc, RegWrite, MemRead, MemWrite, ExtOp, instr_done, illegal;
  logic [1:0] RegDst, MemtoReg, PCSrc;
  logic [2:0] ALUOp;
  logic [2:0] state;
  logic [17:0] act;

  typedef struct {
    string       tag;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        rdy;
    logic [2:0]  st;
    logic [17:0] v;
  } row_t;

  row_t sb[$];
  row_t e;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mc_controller #(.STATE_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
`ifdef MCCTRL_MEM_WAIT_EN
    .mem_ready  (mem_ready),
`endif
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .ExtOp      (ExtOp),
    .instr_done (instr_done),
    .illegal    (illegal),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .PCSrc      (PCSrc),
    .ALUOp      (ALUOp),
    .state      (state)
  );

  assign act = {PCWrite, IRWrite, ALUSrc, RegWrite, MemRead, MemWrite, ExtOp, instr_done,
                illegal, RegDst, MemtoReg, PCSrc, ALUOp};

  function automatic logic [17:0] ctl(logic pcw, logic irw, logic alus, logic rw, logic mr,
                                      logic mw, logic ext, logic done, logic ill,
                                      logic [1:0] rd, logic [1:0] m2r, logic [1:0] pcs,
                                      logic [2:0] alu);
    return {pcw, irw, alus, rw, mr, mw, ext, done, ill, rd, m2r, pcs, alu};
  endfunction

  task automatic push(input string tag, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic r, input logic [2:0] st,
                      input logic [17:0] v);
    row_t x;
    x.tag = tag; x.op = o; x.funct = f; x.zero = z; x.rdy = r; x.st = st; x.v = v;
    sb.push_back(x);
  endtask

  // Expected per-cycle table for one whole instruction.
  task automatic push_instr(input string k, input logic z);
    logic [5:0] o, f;
    f = 6'b100000;
    case (k)
      "lw":  o = 6'b100011;
      "sw":  o = 6'b101011;
      "r":   o = 6'b000000;
      "lui": o = 6'b001111;
      "ori": o = 6'b001101;
      "beq": o = 6'b000100;
      "jal": o = 6'b000011;
      "jr":  begin o = 6'b000000; f = 6'b001000; end
      default: o = 6'b111111;
    endcase
    push({k, "/fetch"}, o, f, z, 1'b1, 3'd0, ctl(1,1,0,0,1,0,0,0,0, 2'b00,2'b00,2'b00,3'b000));
    if (k == "bad") begin
      push({k, "/decode"}, o, f, z, 1'b1, 3'd1, ctl(0,0,0,0,0,0,0,0,1, 2'b00,2'b00,2'b00,3'b000));
      return;
    end
    push({k, "/decode"}, o, f, z, 1'b1, 3'd1, ctl(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,3'b000));
    case (k)
      "lw", "sw":
        push({k, "/exec"}, o, f, z, 1'b1, 3'd2, ctl(0,0,1,0,0,0,0,0,0, 2'b00,2'b00,2'b00,3'b001));
      "r":
        push({k, "/exec"}, o, f, z, 1'b1, 3'd2, ctl(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,3'b000));
      "lui":
        push({k, "/exec"}, o, f, z, 1'b1, 3'd2, ctl(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,3'b011));
      "ori":
        push({k, "/exec"}, o, f, z, 1'b1, 3'd2, ctl(0,0,1,0,0,0,1,0,0, 2'b00,2'b00,2'b00,3'b111));
      "beq":
        push({k, "/exec"}, o, f, z, 1'b1, 3'd2, ctl(z,0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b01,3'b010));
      "jal":
        push({k, "/jmp"}, o, f, z, 1'b1, 3'd5, ctl(1,0,0,1,0,0,0,1,0, 2'b10,2'b11,2'b10,3'b000));
      "jr":
        push({k, "/jmp"}, o, f, z, 1'b1, 3'd5, ctl(1,0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b11,3'b000));
      default: ;
    endcase
    case (k)
      "lw": begin
        push({k, "/mem"}, o, f, z, 1'b1, 3'd3, ctl(0,0,0,0,1,0,0,0,0, 2'b00,2'b00,2'b00,3'b000));
        push({k, "/wb"}, o, f, z, 1'b1, 3'd4, ctl(0,0,0,1,0,0,0,1,0, 2'b00,2'b10,2'b00,3'b000));
      end
      "sw":
        push({k, "/mem"}, o, f, z, 1'b1, 3'd3, ctl(0,0,0,0,0,1,0,1,0, 2'b00,2'b00,2'b00,3'b000));
      "r":
        push({k, "/wb"}, o, f, z, 1'b1, 3'd4, ctl(0,0,0,1,0,0,0,1,0, 2'b01,2'b00,2'b00,3'b000));
      "lui":
        push({k, "/wb"}, o, f, z, 1'b1, 3'd4, ctl(0,0,0,1,0,0,0,1,0, 2'b00,2'b01,2'b00,3'b000));
      "ori":
        push({k, "/wb"}, o, f, z, 1'b1, 3'd4, ctl(0,0,0,1,0,0,0,1,0, 2'b00,2'b00,2'b00,3'b000));
      default: ;
    endcase
  endtask

  task automatic test_reset;
    logic rw_seen;
    reset = 1'b1; op = 6'b100011; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (state !== 3'd0 || act !== 18'd0) begin
      n_err++;
      $display("FAIL reset_hold: state=%0d ctrl=%h, want state=0 ctrl=0", state, act);
    end
    @(posedge clk); #1 reset = 1'b0;
    push_instr("lw", 1'b0);
    repeat (2) void'(sb.pop_back());
    while (sb.size() > 0) begin
      e = sb.pop_front();
      op = e.op; funct = e.funct; zero = e.zero; mem_ready = e.rdy;
      @(negedge clk);
      n_chk++;
      if (state !== e.st || act !== e.v) begin
        n_err++;
        $display("FAIL %s: state=%0d ctrl=%h, want state=%0d ctrl=%h", e.tag, state, act,
                 e.st, e.v);
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (state !== 3'd3) begin
      n_err++;
      $display("FAIL reset_pre_mem: state=%0d, want 3", state);
    end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (state !== 3'd0 || act !== 18'd0) begin
      n_err++;
      $display("FAIL reset_async: state=%0d ctrl=%h, want state=0 ctrl=0", state, act);
    end
    rw_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (RegWrite === 1'b1) rw_seen = 1'b1;
    end
    n_chk++;
    if (rw_seen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_regwrite: seen=%0b, want 0", rw_seen);
    end
    @(posedge clk); #1 reset = 1'b0;
    push_instr("lw", 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      op = e.op; funct = e.funct; zero = e.zero; mem_ready = e.rdy;
      @(negedge clk);
      n_chk++;
      if (state !== e.st || act !== e.v) begin
        n_err++;
        $display("FAIL post_reset_%s: state=%0d ctrl=%h, want state=%0d ctrl=%h", e.tag, state,
                 act, e.st, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_ops;
    push_instr("lw", 1'b0);
    push_instr("sw", 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      op = e.op; funct = e.funct; zero = e.zero; mem_ready = e.rdy;
      @(negedge clk);
      n_chk++;
      if (state !== e.st || act !== e.v) begin
        n_err++;
        $display("FAIL %s: state=%0d ctrl=%h, want state=%0d ctrl=%h", e.tag, state, act,
                 e.st, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_ops;
    push_instr("r", 1'b0);
    push_instr("lui", 1'b1);
    push_instr("ori", 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      op = e.op; funct = e.funct; zero = e.zero; mem_ready = e.rdy;
      @(negedge clk);
      n_chk++;
      if (state !== e.st || act !== e.v) begin
        n_err++;
        $display("FAIL %s: state=%0d ctrl=%h, want state=%0d ctrl=%h", e.tag, state, act,
                 e.st, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump;
    push_instr("beq", 1'b1);
    push_instr("beq", 1'b0);
    push_instr("jal", 1'b0);
    push_instr("jr", 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      op = e.op; funct = e.funct; zero = e.zero; mem_ready = e.rdy;
      @(negedge clk);
      n_chk++;
      if (state !== e.st || act !== e.v) begin
        n_err++;
        $display("FAIL %s z=%0b: state=%0d ctrl=%h, want state=%0d ctrl=%h", e.tag, e.zero,
                 state, act, e.st, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal;
    push_instr("bad", 1'b0);
    push_instr("r", 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      op = e.op; funct = e.funct; zero = e.zero; mem_ready = e.rdy;
      @(negedge clk);
      n_chk++;
      if (state !== e.st || act !== e.v) begin
        n_err++;
        $display("FAIL %s: state=%0d ctrl=%h, want state=%0d ctrl=%h", e.tag, state, act,
                 e.st, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    push_instr("sw", 1'b0);
    push_instr("jr", 1'b0);
    push_instr("lw", 1'b1);
    push_instr("bad", 1'b1);
    push_instr("beq", 1'b1);
    push_instr("ori", 1'b1);
    push_instr("jal", 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      op = e.op; funct = e.funct; zero = e.zero; mem_ready = e.rdy;
      @(negedge clk);
      n_chk++;
      if (state !== e.st || act !== e.v) begin
        n_err++;
        $display("FAIL b2b_%s: state=%0d ctrl=%h, want state=%0d ctrl=%h", e.tag, state, act,
                 e.st, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef MCCTRL_MEM_WAIT_EN
  task automatic test_mem_wait;
    logic [5:0] o;
    o = 6'b101011;
    push("wait/fetch_stall", o, 6'd0, 1'b0, 1'b0, 3'd0,
         ctl(0,0,0,0,1,0,0,0,0, 2'b00,2'b00,2'b00,3'b000));
    push_instr("sw", 1'b0);
    void'(sb.pop_back());
    for (int i = 0; i < 3; i++)
      push("wait/mem_stall", o, 6'd0, 1'b0, 1'b0, 3'd3,
           ctl(0,0,0,0,0,1,0,0,0, 2'b00,2'b00,2'b00,3'b000));
    push("wait/mem_ready", o, 6'd0, 1'b0, 1'b1, 3'd3,
         ctl(0,0,0,0,0,1,0,1,0, 2'b00,2'b00,2'b00,3'b000));
    push_instr("r", 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      op = e.op; funct = e.funct; zero = e.zero; mem_ready = e.rdy;
      @(negedge clk);
      n_chk++;
      if (state !== e.st || act !== e.v) begin
        n_err++;
        $display("FAIL %s: state=%0d ctrl=%h, want state=%0d ctrl=%h", e.tag, state, act,
                 e.st, e.v);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mem_ops();
    test_alu_ops();
    test_branch_jump();
    test_illegal();
    test_back_to_back();
`ifdef MCCTRL_MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
